// File: rtl/stream_merge_pkg.sv
// stream_merge_pkg: shared types and sizing helpers for the two-input round-robin stream merge
package stream_merge_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int BURST_LEN_DEF = 4;
  typedef enum logic [1:0] {IDLE, SERVE1, SERVE2} arb_state_t;
  function automatic int cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction
  localparam int CNT_W_DEF = cnt_w(BURST_LEN_DEF);
  function automatic arb_state_t serve_st(input logic s);
    return s ? SERVE2 : SERVE1;
  endfunction
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: small power-of-two FIFO whose ready comes only from the registered fill count
module stream_fifo
  import stream_merge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid_i,
  input  logic [DATA_W-1:0]           wr_data_i,
  output logic                        wr_ready_o,
  input  logic                        rd_en_i,
  output logic [DATA_W-1:0]           rd_data_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic wr, rd;
  assign full_o = count_q == (AW+1)'(FIFO_DEPTH);
  assign empty_o = count_q == '0;
  assign wr_ready_o = !full_o && !rst;
  assign wr = wr_valid_i && wr_ready_o;
  assign rd = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/stream_merge_rr.sv
// stream_merge_rr: two buffered AXI4-Stream inputs merged by a burst-granular round-robin arbiter
module stream_merge_rr
  import stream_merge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DATA_W-1:0] Input_1_V_TDATA,
  input  logic              Input_1_V_TVALID,
  output logic              Input_1_V_TREADY,
  input  logic [DATA_W-1:0] Input_2_V_TDATA,
  input  logic              Input_2_V_TVALID,
  output logic              Input_2_V_TREADY,
  output logic [DATA_W-1:0] Output_1_V_TDATA,
  output logic              Output_1_V_TVALID,
  input  logic              Output_1_V_TREADY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = cnt_w(BURST_LEN);
  logic [DATA_W-1:0] dout [2];
  logic [AW:0] fcnt [2];
  logic [1:0] empty_w, full_w, rdy_w, wr_w, rd_w, last_w;
  arb_state_t state_q, state_d;
  logic ptr_q, ptr_d;
  logic [CW-1:0] bcnt_q, bcnt_d, bcnt_inc;
  logic sel, load, rearb;
  logic out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic unused_ok;
  assign unused_ok = ap_start ^ (|full_w);
  assign ap_done = 1'b0;
  assign ap_ready = 1'b0;
  assign ap_idle = (&empty_w) && !out_valid_q;
  assign Input_1_V_TREADY = rdy_w[0];
  assign Input_2_V_TREADY = rdy_w[1];
  assign Output_1_V_TDATA = out_data_q;
  assign Output_1_V_TVALID = out_valid_q;
  assign wr_w = {Input_2_V_TVALID, Input_1_V_TVALID} & rdy_w;
  assign rd_w = {load && sel, load && !sel};
  assign last_w = {fcnt[1] == (AW+1)'(1) && !wr_w[1], fcnt[0] == (AW+1)'(1) && !wr_w[0]};
  stream_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(ap_clk), .rst(ap_rst),
    .wr_valid_i(Input_1_V_TVALID), .wr_data_i(Input_1_V_TDATA), .wr_ready_o(rdy_w[0]),
    .rd_en_i(rd_w[0]), .rd_data_o(dout[0]),
    .empty_o(empty_w[0]), .full_o(full_w[0]), .count_o(fcnt[0])
  );
  stream_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk(ap_clk), .rst(ap_rst),
    .wr_valid_i(Input_2_V_TVALID), .wr_data_i(Input_2_V_TDATA), .wr_ready_o(rdy_w[1]),
    .rd_en_i(rd_w[1]), .rd_data_o(dout[1]),
    .empty_o(empty_w[1]), .full_o(full_w[1]), .count_o(fcnt[1])
  );
  // IDLE picks combinationally so the first word of a burst loads in the cycle it is selected
  always_comb begin
    sel = state_q == SERVE2 ? 1'b1 : state_q == SERVE1 ? 1'b0 :
          empty_w[0] ? 1'b1 : empty_w[1] ? 1'b0 : ptr_q;
    load = (!out_valid_q || Output_1_V_TREADY) && !empty_w[sel];
    bcnt_inc = bcnt_q + CW'(1);
    rearb = bcnt_inc == CW'(BURST_LEN) || last_w[sel];
    state_d = state_q;
    ptr_d = ptr_q;
    bcnt_d = bcnt_q;
    if (load) begin
      bcnt_d = rearb ? '0 : bcnt_inc;
      ptr_d = rearb ? !sel : ptr_q;
      state_d = !rearb ? serve_st(sel) : !empty_w[!sel] ? serve_st(!sel) :
                !last_w[sel] ? serve_st(sel) : IDLE;
    end
    out_valid_d = load || (out_valid_q && !Output_1_V_TREADY);
    out_data_d = load ? dout[sel] : out_data_q;
  end
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      bcnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      bcnt_q <= bcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_stream_merge_rr.sv
// tb_stream_merge_rr: directed and randomized checks of the round-robin merge against a queue model
module tb_stream_merge_rr;
  localparam int BL = 4;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ap_start = 1'b0;
  logic ap_done, ap_idle, ap_ready;
  logic [31:0] Input_1_V_TDATA = '0, Input_2_V_TDATA = '0, Output_1_V_TDATA;
  logic Input_1_V_TVALID = 1'b0, Input_2_V_TVALID = 1'b0, Output_1_V_TREADY = 1'b0;
  logic Input_1_V_TREADY, Input_2_V_TREADY, Output_1_V_TVALID;
  always #5 ap_clk = ~ap_clk;
  stream_merge_rr #(.DATA_W(32), .FIFO_DEPTH(4), .BURST_LEN(BL)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .Input_1_V_TDATA(Input_1_V_TDATA), .Input_1_V_TVALID(Input_1_V_TVALID), .Input_1_V_TREADY(Input_1_V_TREADY),
    .Input_2_V_TDATA(Input_2_V_TDATA), .Input_2_V_TVALID(Input_2_V_TVALID), .Input_2_V_TREADY(Input_2_V_TREADY),
    .Output_1_V_TDATA(Output_1_V_TDATA), .Output_1_V_TVALID(Output_1_V_TVALID), .Output_1_V_TREADY(Output_1_V_TREADY)
  );
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] src [2][$];
  logic [31:0] pend [2][$];
  logic [31:0] out_log [$];
  logic [31:0] dlog [$];
  logic [31:0] exp_q [$];
  logic vlog [$];
  int wait_n [2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] a_w(input int i);
    return 32'h0000_00A0 + 32'(i);
  endfunction
  function automatic logic [31:0] b_w(input int i);
    return 32'h8000_00B0 + 32'(i);
  endfunction
  task automatic emit(input logic [31:0] d);
    int s;
    logic [31:0] e;
    s = int'(d[31]);
    e = ~d;
    if (pend[s].size() > 0) e = pend[s].pop_front();
    check("order", d, e);
    wait_n[s] = 0;
    if (pend[1-s].size() > 0) begin
      wait_n[1-s]++;
      check("starve", 32'(wait_n[1-s] > BL + 1), 32'(0));
    end else wait_n[1-s] = 0;
  endtask
  task automatic step(input bit e1, input bit e2, input bit rdy);
    bit a1, a2;
    vlog.push_back(Output_1_V_TVALID);
    dlog.push_back(Output_1_V_TDATA);
    check("idle", 32'(ap_idle), 32'(pend[0].size() == 0 && pend[1].size() == 0));
    Input_1_V_TVALID = e1 && src[0].size() > 0;
    Input_1_V_TDATA = Input_1_V_TVALID ? src[0][0] : '0;
    Input_2_V_TVALID = e2 && src[1].size() > 0;
    Input_2_V_TDATA = Input_2_V_TVALID ? src[1][0] : '0;
    Output_1_V_TREADY = rdy;
    a1 = Input_1_V_TVALID && Input_1_V_TREADY;
    a2 = Input_2_V_TVALID && Input_2_V_TREADY;
    if (Output_1_V_TVALID && rdy) begin
      out_log.push_back(Output_1_V_TDATA);
      emit(Output_1_V_TDATA);
    end
    if (a1) pend[0].push_back(src[0].pop_front());
    if (a2) pend[1].push_back(src[1].pop_front());
    @(negedge ap_clk);
  endtask
  task automatic do_reset();
    ap_rst = 1'b1;
    Input_1_V_TVALID = 1'b0;
    Input_2_V_TVALID = 1'b0;
    Output_1_V_TREADY = 1'b0;
    #1;
    check("rst_in_rdy1", 32'(Input_1_V_TREADY), 32'(0));
    check("rst_in_rdy2", 32'(Input_2_V_TREADY), 32'(0));
    check("rst_in_valid", 32'(Output_1_V_TVALID), 32'(0));
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      pend[s].delete();
      src[s].delete();
      wait_n[s] = 0;
    end
    out_log.delete();
    dlog.delete();
    vlog.delete();
    @(negedge ap_clk);
    check("rst_valid", 32'(Output_1_V_TVALID), 32'(0));
    check("rst_data", Output_1_V_TDATA, 32'(0));
    check("rst_rdy1", 32'(Input_1_V_TREADY), 32'(1));
    check("rst_rdy2", 32'(Input_2_V_TREADY), 32'(1));
    check("rst_idle", 32'(ap_idle), 32'(1));
  endtask
  task automatic check_seq(input string tag);
    check({tag, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) check(tag, out_log[i], exp_q[i]);
  endtask
  task automatic fill_ab();
    for (int i = 0; i < 8; i++) begin
      src[0].push_back(a_w(i));
      src[1].push_back(b_w(i));
    end
    exp_q.delete();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) exp_q.push_back(k % 2 == 0 ? a_w(4 * (k / 2) + i) : b_w(4 * (k / 2) + i));
  endtask
  initial begin
    int pv1 [4] = '{90, 50, 100, 30};
    int pv2 [4] = '{90, 50, 100, 80};
    int pr [4] = '{90, 30, 50, 80};
    int f, ones;
    @(negedge ap_clk);
    do_reset();
    check("ap_done", 32'(ap_done), 32'(0));
    check("ap_ready", 32'(ap_ready), 32'(0));
    for (int i = 0; i < 8; i++) src[0].push_back(32'h10 + 32'(i));
    repeat (12) step(1, 0, 1);
    check("single_lat", 32'(vlog[1]), 32'(0));
    for (int i = 2; i < 10; i++) begin
      check("single_v", 32'(vlog[i]), 32'(1));
      check("single_d", dlog[i], 32'h10 + 32'(i - 2));
    end
    check("single_end", 32'(vlog[10]), 32'(0));
    do_reset();
    fill_ab();
    repeat (30) step(1, 1, 1);
    check_seq("contend");
    do_reset();
    fill_ab();
    repeat (10) step(1, 1, 0);
    for (int i = 2; i < 10; i++) begin
      check("bp_hold_v", 32'(vlog[i]), 32'(1));
      check("bp_hold_d", dlog[i], a_w(0));
    end
    check("bp_rdy1", 32'(Input_1_V_TREADY), 32'(0));
    check("bp_rdy2", 32'(Input_2_V_TREADY), 32'(0));
    repeat (30) step(1, 1, 1);
    check_seq("bp_order");
    do_reset();
    src[0].push_back(a_w(0));
    src[0].push_back(a_w(1));
    exp_q.delete();
    exp_q.push_back(a_w(0));
    exp_q.push_back(a_w(1));
    for (int i = 0; i < 8; i++) begin
      src[1].push_back(b_w(i));
      exp_q.push_back(b_w(i));
    end
    repeat (30) step(1, 1, 1);
    check_seq("dry");
    f = 0;
    while (f < vlog.size() - 1 && !vlog[f]) f++;
    ones = 0;
    for (int i = f; i < f + 10 && i < vlog.size(); i++) ones += int'(vlog[i]);
    check("dry_gapless", 32'(ones), 32'(10));
    do_reset();
    for (int i = 0; i < 4; i++) src[0].push_back(32'h0000_00C0 + 32'(i));
    repeat (6) step(1, 0, 0);
    check("pre_rst_valid", 32'(Output_1_V_TVALID), 32'(1));
    check("pre_rst_idle", 32'(ap_idle), 32'(0));
    do_reset();
    repeat (5) step(0, 0, 1);
    for (int i = 0; i < 5; i++) check("no_stale", 32'(vlog[i]), 32'(0));
    do_reset();
    for (int i = 0; i < 12000; i++) begin
      src[0].push_back(32'(i));
      src[1].push_back(32'h8000_0000 | 32'(i));
    end
    for (int r = 0; r < 10000; r++)
      step($urandom_range(99) < 32'(pv1[r / 2500]), $urandom_range(99) < 32'(pv2[r / 2500]),
           $urandom_range(99) < 32'(pr[r / 2500]));
    repeat (40) step(0, 0, 1);
    check("drain1", 32'(pend[0].size()), 32'(0));
    check("drain2", 32'(pend[1].size()), 32'(0));
    check("final_idle", 32'(ap_idle), 32'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
